// File: rtl/dcache_ctrl_pkg.sv
// Shared geometry, address-field positions and FSM encoding for the direct-mapped data cache.
// Used by the controller, the line array and the verification environment.
package dcache_ctrl_pkg;

    localparam int unsigned NUM_BLOCKS  = 8;
    localparam int unsigned BLOCK_BYTES = 4;
    localparam int unsigned TAG_W       = 3;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned OFF_W       = 2;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned BLK_ADDR_W  = TAG_W + IDX_W;
    localparam int unsigned BLOCK_W     = BLOCK_BYTES * 8;

    // ADDRESS = {tag[7:5], index[4:2], offset[1:0]}
    localparam int unsigned TAG_HI = 7;
    localparam int unsigned TAG_LO = 5;
    localparam int unsigned IDX_HI = 4;
    localparam int unsigned IDX_LO = 2;
    localparam int unsigned OFF_HI = 1;
    localparam int unsigned OFF_LO = 0;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WRITE_BACK = 2'd1;
    localparam logic [1:0] ST_MEM_READ   = 2'd2;
    localparam logic [1:0] ST_UPDATE     = 2'd3;

    function automatic logic [7:0] sel_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFF_W-1:0]   off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Register-based valid/dirty/tag/data storage for the cache lines.
// Combinational lookup with tag compare; registered byte store or whole-line refill.
module dcache_line_array
    import dcache_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               hit_o,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [BLOCK_W-1:0] data_o,
    input  logic               byte_we_i,
    input  logic [OFF_W-1:0]   off_i,
    input  logic [7:0]         byte_i,
    input  logic               blk_we_i,
    input  logic [BLOCK_W-1:0] blk_i
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    always_comb begin
        valid_o = valid_q[idx_i];
        dirty_o = dirty_q[idx_i];
        tag_o   = tag_q[idx_i];
        data_o  = data_q[idx_i];
        hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    end

    // Refill wins over a byte store; a refill always leaves the line clean.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '{default: '0};
            data_q  <= '{default: '0};
        end else if (blk_we_i) begin
            data_q[idx_i]  <= blk_i;
            tag_q[idx_i]   <= tag_i;
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (byte_we_i) begin
            data_q[idx_i][{off_i, 3'b000} +: 8] <= byte_i;
            dirty_q[idx_i]                      <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: hit/miss handling, write-back and refill
// sequencing toward word-organised data memory, and CPU stall generation.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [7:0]            WRITEDATA,
    output logic [7:0]            READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [BLK_ADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    logic [1:0]         state_q, state_d;
    logic [BLOCK_W-1:0] fill_q;
    logic [7:0]         readdata_q;

    logic               hit, line_valid, line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               req, byte_we, blk_we;

    assign req     = READ | WRITE;
    assign byte_we = WRITE && hit && (state_q == ST_IDLE);
    assign blk_we  = (state_q == ST_UPDATE);

    dcache_line_array u_lines (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .idx_i     (ADDRESS[IDX_HI:IDX_LO]),
        .tag_i     (ADDRESS[TAG_HI:TAG_LO]),
        .hit_o     (hit),
        .valid_o   (line_valid),
        .dirty_o   (line_dirty),
        .tag_o     (line_tag),
        .data_o    (line_data),
        .byte_we_i (byte_we),
        .off_i     (ADDRESS[OFF_HI:OFF_LO]),
        .byte_i    (WRITEDATA),
        .blk_we_i  (blk_we),
        .blk_i     (fill_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (req && !hit)
                               state_d = (line_valid && line_dirty) ? ST_WRITE_BACK : ST_MEM_READ;
            ST_WRITE_BACK: if (!MEM_BUSYWAIT) state_d = ST_MEM_READ;
            ST_MEM_READ:   if (!MEM_BUSYWAIT) state_d = ST_UPDATE;
            ST_UPDATE:     state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        MEM_WRITE     = (state_q == ST_WRITE_BACK);
        MEM_READ      = (state_q == ST_MEM_READ);
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        if (MEM_WRITE) begin
            MEM_ADDRESS   = {line_tag, ADDRESS[IDX_HI:IDX_LO]};
            MEM_WRITEDATA = line_data;
        end else if (MEM_READ) begin
            MEM_ADDRESS   = ADDRESS[TAG_HI:IDX_LO];
        end
        BUSYWAIT = req && (!hit || (state_q != ST_IDLE));
        // Load data is live on a read hit and otherwise holds the last delivered byte.
        READDATA = (READ && !WRITE && hit && (state_q == ST_IDLE))
                   ? sel_byte(line_data, ADDRESS[OFF_HI:OFF_LO]) : readdata_q;
    end

    // The refill word is captured at transfer completion and written into the line in UPDATE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            fill_q     <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            readdata_q <= READDATA;
            if ((state_q == ST_MEM_READ) && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
        end
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back data cache between the CPU datapath and the word-organised data memory.
- The ALU result drives ADDRESS for load/store instructions. The cache is the responder to the CPU's memory requests and the initiator toward data memory.
- It stalls the CPU through BUSYWAIT while a miss is serviced.
- Geometry: 8 blocks × 4 bytes, 8-bit byte address.

Parameters:
- NUM_BLOCKS, 8, number of cache lines. Only the default is supported.
- BLOCK_BYTES, 4, bytes per line. This equals one 32-bit memory word.
- TAG_W, 3, tag width. ADDRESS[7:5] is the tag, [4:2] the index, [1:0] the byte offset.

Ports:
- CLK  in  1  system clock. All state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address.
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  CPU load data.
- BUSYWAIT  out  1  CPU stall. High means the request is not yet complete.
- MEM_READ  out  1  memory block-read request.
- MEM_WRITE  out  1  memory block-write request.
- MEM_ADDRESS  out  6  memory block address (tag & index).
- MEM_WRITEDATA  out  32  block written back; byte 0 in [7:0].
- MEM_READDATA  in  32  block returned by memory.
- MEM_BUSYWAIT  in  1  memory busy. A transfer completes on the first cycle this is low while a request is held.

Behaviour:
- Per-line storage: valid bit, dirty bit, 3-bit tag, 32-bit data. The arrays are held in registers.
- Hit condition (combinational): valid[index] && tag[index] == ADDRESS[7:5].
- Reset (RESET high at a rising edge):
  - all valid and dirty bits cleared; state set to IDLE.
  - MEM_READ, MEM_WRITE, BUSYWAIT and READDATA all 0; MEM_ADDRESS and MEM_WRITEDATA 0.
  - Reset mid-miss aborts the memory transfer. MEM_READ and MEM_WRITE are low from the following cycle, and no line is updated.
- FSM states: IDLE, WRITE_BACK, MEM_READ, UPDATE.
  - IDLE, request with hit: stay in IDLE.
  - IDLE, miss on a clean or invalid line: go to MEM_READ.
  - IDLE, miss on a dirty line: go to WRITE_BACK.
  - WRITE_BACK: MEM_WRITE=1, MEM_ADDRESS={old tag, index}, MEM_WRITEDATA=line data. On the cycle MEM_BUSYWAIT is low, go to MEM_READ.
  - MEM_READ: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]. On the cycle MEM_BUSYWAIT is low, go to UPDATE.
  - UPDATE: one cycle. Write MEM_READDATA into the line; set tag=ADDRESS[7:5], valid=1, dirty=0; go to IDLE.
  - After UPDATE the request re-evaluates in IDLE as a hit.
- BUSYWAIT (combinational):
  - high when (READ|WRITE) is asserted and either the access misses or state != IDLE.
  - low otherwise, including idle cycles with no request.
- Read hit: READDATA is the selected byte of the line in the same cycle. BUSYWAIT stays low, so there is zero stall cycles.
- Write hit: WRITEDATA is written into the selected byte at the next rising edge and dirty is set. BUSYWAIT stays low.
- Read miss, clean line: BUSYWAIT is high for the memory latency plus 2 cycles (MEM_READ completion, then UPDATE).
- Miss on a dirty line: the write-back transfer is added in front of the read.
- READ and WRITE both high: WRITE takes priority; the access is treated as a store.
- The CPU holds READ, WRITE, ADDRESS and WRITEDATA stable while BUSYWAIT is high. The cache does not latch them separately.
- MEM_READ and MEM_WRITE are never high together.
- READDATA is undefined (held at its last value) when READ is low.

Decomposition:
- Shared package: FSM state encoding, geometry constants (NUM_BLOCKS, BLOCK_BYTES, TAG_W), and address-field slice positions. The package is reused by the memory model and the bench.
- Natural sub-module: dcache_line_array, which holds the valid/dirty/tag/data storage. It provides a combinational read with hit compare and a registered write with byte or block select.
- The FSM and port logic stay in dcache_ctrl.

Test Plan:
- Reset, then READ ADDRESS=0x00 with memory returning 0x44332211 after 5 busy cycles → BUSYWAIT high until UPDATE completes, then READDATA=0x11 and BUSYWAIT=0.
- Immediately after that, READ ADDRESS=0x03 → same-cycle hit, READDATA=0x44, BUSYWAIT never asserted, MEM_READ=0.
- WRITE 0xAB to 0x01 (hit), then READ 0x01 → READDATA=0xAB; line 0 dirty; no memory traffic.
- READ 0x20 (index 0, tag 1) with line 0 dirty → MEM_WRITE with MEM_ADDRESS=0x00 and MEM_WRITEDATA=0x4433AB11; then MEM_READ with MEM_ADDRESS=0x08; then UPDATE; line is clean afterwards.
- RESET asserted during the MEM_READ state → MEM_READ=0 on the next cycle; re-reading 0x20 misses (valid bits cleared).
- READ and WRITE both high on a hit at 0x02 with WRITEDATA=0x5C → store performed; a subsequent READ of 0x02 returns 0x5C.
